// File: rtl/game_pkg.sv
// Shared types and defaults for the fighter health logic.
package game_pkg;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } fighter_state_t;

    localparam int HP_W                     = 8;
    localparam int DEF_MAX_HP               = 100;
    localparam int DEF_INVULN_FRAMES        = 30;
    localparam int DEF_DEAD_HOLD_FRAMES     = 60;

    // Counter width large enough for the longer of the two frame timers.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fighter_health.sv
// One fighter: HP register, ALIVE/INVULN/DEAD FSM and a shared frame counter.
module fighter_health
    import game_pkg::*;
#(
    parameter int MAX_HP           = DEF_MAX_HP,
    parameter int INVULN_FRAMES    = DEF_INVULN_FRAMES,
    parameter int DEAD_HOLD_FRAMES = DEF_DEAD_HOLD_FRAMES
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            i_start,
    input  logic            i_battle,
    input  logic            i_hit,
    input  logic [3:0]      i_dmg,
    output logic [HP_W-1:0] o_hp,
    output logic            o_dead,
    output logic            o_invuln
);

    localparam int CNT_W = cnt_width(INVULN_FRAMES, DEAD_HOLD_FRAMES);
    localparam logic [HP_W-1:0]  MAX_HP_V = HP_W'(MAX_HP);
    localparam logic [CNT_W-1:0] INV_V    = CNT_W'(INVULN_FRAMES);
    localparam logic [CNT_W-1:0] HOLD_V   = CNT_W'(DEAD_HOLD_FRAMES);
    localparam logic [CNT_W-1:0] ONE_V    = CNT_W'(1);

    fighter_state_t   r_state;
    logic [HP_W-1:0]  r_hp;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dead;
    logic             r_invuln;

    logic             w_hit_ok;
    logic [HP_W-1:0]  w_dmg_ext;
    logic [HP_W-1:0]  w_hp_after;

    assign w_dmg_ext  = {{(HP_W-4){1'b0}}, i_dmg};
    assign w_hit_ok   = i_hit && (i_dmg != 4'd0) && i_battle && (r_state == ALIVE);
    // Saturate at zero instead of wrapping.
    assign w_hp_after = (r_hp > w_dmg_ext) ? (r_hp - w_dmg_ext) : '0;

    always_ff @(posedge clk) begin
        if (srst || i_start) begin
            r_state  <= ALIVE;
            r_hp     <= MAX_HP_V;
            r_cnt    <= '0;
            r_dead   <= 1'b0;
            r_invuln <= 1'b0;
        end else begin
            case (r_state)
                ALIVE: begin
                    if (w_hit_ok) begin
                        r_hp <= w_hp_after;
                        if (w_hp_after == '0) begin
                            r_state <= DEAD;
                            r_cnt   <= HOLD_V;
                            r_dead  <= 1'b1;
                        end else begin
                            r_state  <= INVULN;
                            r_cnt    <= INV_V;
                            r_invuln <= 1'b1;
                        end
                    end
                end
                INVULN: begin
                    if (r_cnt <= ONE_V) begin
                        r_state  <= ALIVE;
                        r_cnt    <= '0;
                        r_invuln <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - ONE_V;
                    end
                end
                DEAD: begin
                    // Release refills HP so the next round starts fresh.
                    if (r_cnt <= ONE_V) begin
                        r_state <= ALIVE;
                        r_cnt   <= '0;
                        r_dead  <= 1'b0;
                        r_hp    <= MAX_HP_V;
                    end else begin
                        r_cnt <= r_cnt - ONE_V;
                    end
                end
                default: begin
                    r_state  <= ALIVE;
                    r_hp     <= MAX_HP_V;
                    r_cnt    <= '0;
                    r_dead   <= 1'b0;
                    r_invuln <= 1'b0;
                end
            endcase
        end
    end

    assign o_hp     = r_hp;
    assign o_dead   = r_dead;
    assign o_invuln = r_invuln;

endmodule

// File: rtl/health_control.sv
// Health tracking for the player and NPC; index 0 is the player, 1 the NPC.
module health_control
    import game_pkg::*;
#(
    parameter int MAX_HP           = DEF_MAX_HP,
    parameter int INVULN_FRAMES    = DEF_INVULN_FRAMES,
    parameter int DEAD_HOLD_FRAMES = DEF_DEAD_HOLD_FRAMES
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            start_l,
    input  logic            battle_l,
    input  logic            Player_Hit,
    input  logic            NPC_Hit,
    input  logic [3:0]      Player_Dmg,
    input  logic [3:0]      NPC_Dmg,
    output logic [HP_W-1:0] Player_HP,
    output logic [HP_W-1:0] NPC_HP,
    output logic            Player_Dead,
    output logic            NPC_Dead,
    output logic            Player_Invuln,
    output logic            NPC_Invuln
);

    logic [1:0]      w_hit;
    logic [3:0]      w_dmg    [2];
    logic [HP_W-1:0] w_hp     [2];
    logic [1:0]      w_dead;
    logic [1:0]      w_invuln;

    assign w_hit    = {NPC_Hit, Player_Hit};
    assign w_dmg[0] = Player_Dmg;
    assign w_dmg[1] = NPC_Dmg;

    // Fighters never interact, so simultaneous deaths are reported independently.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fighter
            fighter_health #(
                .MAX_HP           (MAX_HP),
                .INVULN_FRAMES    (INVULN_FRAMES),
                .DEAD_HOLD_FRAMES (DEAD_HOLD_FRAMES)
            ) u_fighter (
                .clk      (Clk),
                .srst     (Reset),
                .i_start  (start_l),
                .i_battle (battle_l),
                .i_hit    (w_hit[gi]),
                .i_dmg    (w_dmg[gi]),
                .o_hp     (w_hp[gi]),
                .o_dead   (w_dead[gi]),
                .o_invuln (w_invuln[gi])
            );
        end
    endgenerate

    assign Player_HP     = w_hp[0];
    assign NPC_HP        = w_hp[1];
    assign Player_Dead   = w_dead[0];
    assign NPC_Dead      = w_dead[1];
    assign Player_Invuln = w_invuln[0];
    assign NPC_Invuln    = w_invuln[1];

endmodule

// File: tb/tb_health_control.sv
// Self-checking bench for health_control with default parameters.
module tb_health_control;

    typedef struct {
        logic       rst, st, bt, ph;
        logic [3:0] pd;
        logic       nh;
        logic [3:0] nd;
        logic [7:0] e_php, e_nhp;
        logic       e_pdead, e_ndead, e_pinv, e_ninv;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1, start_l = 1'b0, battle_l = 1'b0;
    logic       Player_Hit = 1'b0, NPC_Hit = 1'b0;
    logic [3:0] Player_Dmg = 4'd0, NPC_Dmg = 4'd0;
    logic [7:0] Player_HP, NPC_HP;
    logic       Player_Dead, NPC_Dead, Player_Invuln, NPC_Invuln;

    int    n_checks = 0;
    int    n_errors = 0;
    vec_t  exp_q [$];
    string tag_q [$];
    vec_t  tbl [5];

    health_control dut (
        .Clk(Clk), .Reset(Reset), .start_l(start_l), .battle_l(battle_l),
        .Player_Hit(Player_Hit), .NPC_Hit(NPC_Hit),
        .Player_Dmg(Player_Dmg), .NPC_Dmg(NPC_Dmg),
        .Player_HP(Player_HP), .NPC_HP(NPC_HP),
        .Player_Dead(Player_Dead), .NPC_Dead(NPC_Dead),
        .Player_Invuln(Player_Invuln), .NPC_Invuln(NPC_Invuln)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic rst, input logic st, input logic bt,
                                input logic ph, input logic [3:0] pd,
                                input logic nh, input logic [3:0] nd,
                                input logic [7:0] php, input logic [7:0] nhp,
                                input logic pdd, input logic ndd,
                                input logic pi, input logic ni);
        vec_t v;
        v.rst = rst; v.st = st; v.bt = bt; v.ph = ph; v.pd = pd; v.nh = nh; v.nd = nd;
        v.e_php = php; v.e_nhp = nhp; v.e_pdead = pdd; v.e_ndead = ndd;
        v.e_pinv = pi; v.e_ninv = ni;
        return v;
    endfunction

    task automatic chk(input string tag, input string what, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s %s: got %0d expected %0d", tag, what, act, req);
        end
    endtask

    // Drive one frame, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string tag);
        vec_t  e;
        string t;
        Reset = v.rst; start_l = v.st; battle_l = v.bt;
        Player_Hit = v.ph; Player_Dmg = v.pd; NPC_Hit = v.nh; NPC_Dmg = v.nd;
        exp_q.push_back(v);
        tag_q.push_back(tag);
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, "Player_HP", Player_HP, e.e_php);
        chk(t, "NPC_HP", NPC_HP, e.e_nhp);
        chk(t, "Player_Dead", Player_Dead, e.e_pdead);
        chk(t, "NPC_Dead", NPC_Dead, e.e_ndead);
        chk(t, "Player_Invuln", Player_Invuln, e.e_pinv);
        chk(t, "NPC_Invuln", NPC_Invuln, e.e_ninv);
        $display("step %-10s rst=%0b st=%0b bt=%0b P(hit=%0b dmg=%0d hp=%0d dead=%0b inv=%0b) N(hit=%0b dmg=%0d hp=%0d dead=%0b inv=%0b)",
                 t, v.rst, v.st, v.bt, v.ph, v.pd, Player_HP, Player_Dead, Player_Invuln,
                 v.nh, v.nd, NPC_HP, NPC_Dead, NPC_Invuln);
    endtask

    // Hit one or both fighters, then idle through the whole invulnerability window.
    task automatic hit_and_wait(input logic [3:0] pd, input logic [3:0] nd,
                                input logic [7:0] php, input logic [7:0] nhp,
                                input string tag);
        logic pi, ni;
        pi = (pd != 4'd0);
        ni = (nd != 4'd0);
        step(mk(0, 0, 1, pi, pd, ni, nd, php, nhp, 0, 0, pi, ni), tag);
        for (int i = 1; i < 30; i++)
            step(mk(0, 0, 1, 0, 0, 0, 0, php, nhp, 0, 0, pi, ni), {tag, "_inv"});
        step(mk(0, 0, 1, 0, 0, 0, 0, php, nhp, 0, 0, 0, 0), {tag, "_end"});
    endtask

    initial begin
        tbl[0] = mk(1, 0, 0, 0, 0,  0, 0,  100, 100, 0, 0, 0, 0);
        tbl[1] = mk(0, 0, 0, 1, 5,  1, 5,  100, 100, 0, 0, 0, 0);
        tbl[2] = mk(0, 0, 1, 1, 0,  1, 0,  100, 100, 0, 0, 0, 0);
        tbl[3] = mk(0, 1, 1, 1, 9,  1, 9,  100, 100, 0, 0, 0, 0);
        tbl[4] = mk(0, 0, 1, 0, 9,  0, 9,  100, 100, 0, 0, 0, 0);
        @(posedge Clk);
        #1;
        for (int i = 0; i < 5; i++)
            step(tbl[i], $sformatf("tbl%0d", i));

        // Player: hit, ignored re-hit during INVULN, accepted re-hit afterwards.
        step(mk(0, 0, 1, 1, 10, 0, 0, 90, 100, 0, 0, 1, 0), "p_hit10");
        for (int i = 1; i < 5; i++)
            step(mk(0, 0, 1, 0, 0, 0, 0, 90, 100, 0, 0, 1, 0), "p_inv");
        step(mk(0, 0, 1, 1, 15, 0, 0, 90, 100, 0, 0, 1, 0), "p_inv_hit");
        for (int i = 6; i < 30; i++)
            step(mk(0, 0, 1, 0, 0, 0, 0, 90, 100, 0, 0, 1, 0), "p_inv");
        step(mk(0, 0, 1, 0, 0, 0, 0, 90, 100, 0, 0, 0, 0), "p_inv_end");
        hit_and_wait(15, 0, 75, 100, "p_hit15");
        hit_and_wait(15, 0, 60, 100, "p_to60");
        hit_and_wait(15, 0, 45, 100, "p_to45");
        step(mk(0, 0, 1, 1, 5, 0, 0, 40, 100, 0, 0, 1, 0), "p_to40");
        step(mk(0, 1, 1, 0, 0, 0, 0, 100, 100, 0, 0, 0, 0), "p_start");

        // NPC: drive down to 5, then overkill into DEAD and hold.
        for (int k = 1; k <= 6; k++)
            hit_and_wait(0, 15, 100, 8'(100 - 15 * k), "n_down");
        hit_and_wait(0, 5, 100, 5, "n_to5");
        step(mk(0, 0, 1, 0, 0, 1, 15, 100, 0, 0, 1, 0, 0), "n_lethal");
        for (int i = 1; i < 60; i++)
            step(mk(0, 0, logic'(i % 2), 0, 0, logic'(i == 10), 15, 100, 0, 0, 1, 0, 0), "n_dead");
        step(mk(0, 0, 1, 0, 0, 0, 0, 100, 100, 0, 0, 0, 0), "n_release");

        // Both fighters down to 3, then simultaneous lethal hits.
        for (int k = 1; k <= 6; k++)
            hit_and_wait(15, 15, 8'(100 - 15 * k), 8'(100 - 15 * k), "b_down");
        hit_and_wait(7, 7, 3, 3, "b_to3");
        step(mk(0, 0, 1, 1, 3, 1, 3, 0, 0, 1, 1, 0, 0), "b_lethal");
        for (int i = 1; i <= 40; i++)
            step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), "b_dead");
        step(mk(1, 1, 1, 1, 9, 1, 9, 100, 100, 0, 0, 0, 0), "rst_dead");
        step(mk(1, 1, 1, 1, 9, 1, 9, 100, 100, 0, 0, 0, 0), "rst_prio");
        step(mk(0, 0, 1, 1, 10, 0, 0, 90, 100, 0, 0, 1, 0), "post_rst");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
